alu_wide_sequencer: RTL and testbench

//  Initiator side of the combinational ALU port (A, B, Ci, OP -> Out, Z, N, C, V).

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_wide_sequencer_if.sv | 29 ++
 rtl/alu_wide_sequencer.sv | 103 ++++++++++
 tb/tb_alu_wide_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the 64-bit add/sub sequencer: ALU opcodes, request opcodes,
// FSM states and the signed-saturation helper.
package alu_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDC = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBB = 4'b0011;

  typedef enum logic {
    OP_ADD64 = 1'b0,
    OP_SUB64 = 1'b1
  } req_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  // An overflowed result with its sign bit set came from a positive overflow.
  function automatic logic [63:0] sat_value(input logic wrapped_sign);
    return wrapped_sign ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
  endfunction

endpackage

// File: rtl/alu_wide_sequencer_if.sv
// Request/response handshake bundle between the issue logic (master) and the
// 64-bit sequencer (slave).
interface alu_wide_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_result;
  logic        resp_z;
  logic        resp_n;
  logic        resp_c;
  logic        resp_v;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_z, resp_n, resp_c, resp_v
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_z, resp_n, resp_c, resp_v
  );

endinterface

// File: rtl/alu_wide_sequencer.sv
// Runs a 64-bit ADD/SUB as two chained passes through an external 32-bit ALU.
// Optional ALU_WIDE_SAT_EN: clamp the result to signed saturation on overflow.
module alu_wide_sequencer
  import alu_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  alu_wide_sequencer_if.slave  bus,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic                 alu_ci,
  output logic [3:0]           alu_op,
  input  logic [31:0]          alu_out,
  input  logic                 alu_z,
  input  logic                 alu_n,
  input  logic                 alu_c,
  input  logic                 alu_v
);

  state_t      state;
  logic        op_sub;
  logic [31:0] a_hi;
  logic [31:0] b_hi;
  logic        lo_zero;
  logic [63:0] full_result;

  assign full_result = {alu_out, bus.resp_result[31:0]};

  // NOTE: all state and outputs update with non-blocking assignments in one
  // clocked block, so every output is a register and the ALU sees stable inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      op_sub          <= 1'b0;
      a_hi            <= '0;
      b_hi            <= '0;
      lo_zero         <= 1'b0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_ci          <= 1'b0;
      alu_op          <= ALU_ADD;
      bus.req_ready   <= 1'b1;
      bus.resp_valid  <= 1'b0;
      bus.resp_result <= '0;
      bus.resp_z      <= 1'b0;
      bus.resp_n      <= 1'b0;
      bus.resp_c      <= 1'b0;
      bus.resp_v      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_sub        <= (req_op_t'(bus.req_op) == OP_SUB64);
            a_hi          <= bus.req_a[63:32];
            b_hi          <= bus.req_b[63:32];
            alu_a         <= bus.req_a[31:0];
            alu_b         <= bus.req_b[31:0];
            alu_ci        <= 1'b0;
            alu_op        <= (req_op_t'(bus.req_op) == OP_SUB64) ? ALU_SUB : ALU_ADD;
            bus.req_ready <= 1'b0;
            state         <= S_LO;
          end
        end
        S_LO: begin
          bus.resp_result[31:0] <= alu_out;
          lo_zero               <= alu_z;
          alu_a                 <= a_hi;
          alu_b                 <= b_hi;
          // The low-word carry/borrow is held in alu_ci for the high pass.
          alu_ci                <= alu_c;
          alu_op                <= op_sub ? ALU_SUBB : ALU_ADDC;
          state                 <= S_HI;
        end
        S_HI: begin
`ifdef ALU_WIDE_SAT_EN
          bus.resp_result <= alu_v ? sat_value(alu_out[31]) : full_result;
`else
          bus.resp_result <= full_result;
`endif
          bus.resp_z     <= lo_zero & alu_z;
          bus.resp_n     <= alu_n;
          bus.resp_c     <= alu_c;
          bus.resp_v     <= alu_v;
          bus.resp_valid <= 1'b1;
          alu_a          <= '0;
          alu_b          <= '0;
          alu_ci         <= 1'b0;
          alu_op         <= ALU_ADD;
          state          <= S_DONE;
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench: a behavioural 32-bit ALU sits beside the sequencer; a scoreboard
// queue holds expected responses and a negedge monitor compares them.
module tb_alu_wide_sequencer;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_wide_sequencer_if bus();

  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_ci;
  logic [3:0]  alu_op;
  logic        alu_z, alu_n, alu_c, alu_v;

  alu_wide_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_ci  (alu_ci),
    .alu_op  (alu_op),
    .alu_out (alu_out),
    .alu_z   (alu_z),
    .alu_n   (alu_n),
    .alu_c   (alu_c),
    .alu_v   (alu_v)
  );

  // External 32-bit ALU: C is carry-out for add, borrow for subtract.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    alu_v   = 1'b0;
    case (alu_op)
      ALU_ADD:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_ADDC: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_ci};
      ALU_SUB:  alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_SUBB: alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - {32'b0, alu_ci};
      default:  alu_sum = '0;
    endcase
    alu_out = alu_sum[31:0];
    alu_c   = alu_sum[32];
    alu_z   = (alu_sum[31:0] == 32'd0);
    alu_n   = alu_sum[31];
    if (alu_op == ALU_SUB || alu_op == ALU_SUBB)
      alu_v = (alu_a[31] != alu_b[31]) && (alu_sum[31] != alu_a[31]);
    else
      alu_v = (alu_a[31] == alu_b[31]) && (alu_sum[31] != alu_a[31]);
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [67:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int accept_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: response must appear in the third cycle after the accept cycle.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.resp_valid && !prev_valid)
        check("latency", 68'(cyc - accept_cyc), 68'd3);
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 68'(bus.resp_result), 68'hX);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(e.name, {bus.resp_result, bus.resp_z, bus.resp_n, bus.resp_c, bus.resp_v},
                e.val);
        end
      end
      prev_valid = bus.resp_valid;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic op, input logic [63:0] a, input logic [63:0] b,
                       input logic expect_resp, input logic [67:0] expv, input string name);
    logic ok;
    ok = 1'b0;
    if (expect_resp) sb.push_back('{expv, name});
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        accept_cyc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (!ok) check({name, "_accept_timeout"}, 68'd0, 68'd1);
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.req_ready && !bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_done_timeout"}, 68'd0, 68'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [63:0] exp_pos_ovf, exp_neg_ovf;
  int          hs_cyc;
  logic        seen_valid;

  initial begin
`ifdef ALU_WIDE_SAT_EN
    exp_pos_ovf = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_neg_ovf = 64'h8000_0000_0000_0000;
`else
    exp_pos_ovf = 64'h8000_0000_0000_0000;
    exp_neg_ovf = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    reset          = 1'b1;
    #2;
    check("rst_req_ready", 68'(bus.req_ready), 68'd1);
    check("rst_resp", {3'b0, bus.resp_valid, bus.resp_result, bus.resp_z, bus.resp_n,
                       bus.resp_c, bus.resp_v}, 68'd0);
    check("rst_alu", 68'({alu_a, alu_b, alu_ci, alu_op}), 68'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: carry from low word into high word
    issue(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1,
          {64'h0000_0001_0000_0000, 4'b0000}, "t1_add_carry");
    wait_done("t1");

    // 2: 0 - 1, borrow chained into the high pass
    issue(1'b1, 64'd0, 64'd1, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 4'b0110}, "t2_sub_borrow");
    @(negedge clk);
    check("t2_lo_ci_op", 68'({alu_ci, alu_op}), 68'({1'b0, 4'b0010}));
    @(negedge clk);
    check("t2_hi_ci_op", 68'({alu_ci, alu_op}), 68'({1'b1, 4'b0011}));
    wait_done("t2");

    // 3: equal operands give zero across both words
    issue(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
          {64'd0, 4'b1000}, "t3_sub_zero");
    wait_done("t3");

    // 4: positive and negative signed overflow
    issue(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, {exp_pos_ovf, 4'b0101}, "t4_pos_ovf");
    wait_done("t4a");
    issue(1'b1, 64'h8000_0000_0000_0000, 64'd1, 1'b1, {exp_neg_ovf, 4'b0001}, "t4_neg_ovf");
    wait_done("t4b");

    // 5: response stall, then a back-to-back request
    bus.resp_ready = 1'b0;
    issue(1'b0, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b1,
          {64'h0000_0004_0000_0006, 4'b0000}, "t5_stalled");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      check("t5_hold", {3'b0, bus.resp_valid, bus.resp_result, bus.resp_z, bus.resp_n,
                        bus.resp_c, bus.resp_v}, {4'b0001, 64'h0000_0004_0000_0006, 4'b0000});
      check("t5_req_ready_low", 68'(bus.req_ready), 68'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    hs_cyc = cyc;
    check("t5_idle_next", 68'(bus.req_ready), 68'd1);
    issue(1'b1, 64'd5, 64'd3, 1'b1, {64'd2, 4'b0000}, "t5_b2b");
    check("t5_b2b_accept", 68'(accept_cyc - hs_cyc), 68'd0);
    wait_done("t5");

    // 6: reset during the high pass aborts with no response
    issue(1'b0, 64'd1, 64'd2, 1'b0, 68'd0, "t6_aborted");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_ready_valid", 68'({bus.req_ready, bus.resp_valid}), 68'({1'b1, 1'b0}));
    check("t6_rst_alu", 68'({alu_a, alu_b, alu_ci, alu_op}), 68'd0);
    check("t6_rst_result", 68'(bus.resp_result), 68'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen_valid = 1'b1;
    end
    check("t6_no_resp", 68'(seen_valid), 68'd0);
    @(posedge clk);
    #1;
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, {64'd0, 4'b1010}, "t6_after_reset");
    wait_done("t6");

    check("sb_empty", 68'(sb.size()), 68'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
